// File: rtl/controle_soneca_pkg.sv
// -----------------------------------------------------------------------------
// controle_soneca_pkg
//   Shared definitions for the alarm-session sequencer: state width,
//   state encodings and default timing parameters.
//   Optional feature macro used by the top: ALARME_FDS_EN.
// -----------------------------------------------------------------------------
package controle_soneca_pkg;

    localparam int ESTADO_W = 2;

    // Encodings are visible on the estado debug port, so they are fixed.
    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO  = 2'd0,
        TOCANDO = 2'd1,
        SONECA  = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam int RING_CYCLES_DEF   = 16;
    localparam int SNOOZE_CYCLES_DEF = 32;
    localparam int MAX_SONECAS_DEF   = 3;
    localparam int CW_DEF            = 8;

endpackage

// File: rtl/controle_soneca_contador_ciclos.sv
// -----------------------------------------------------------------------------
// contador_ciclos
//   CW-bit interval counter with synchronous clear and enable. match flags
//   that the count equals the terminal value selected by the caller.
// Ports
//   clock     in   system clock
//   reset     in   synchronous reset, active-low
//   clr       in   clear count to zero (has priority over en)
//   en        in   increment count
//   terminal  in   CW  value compared against the count
//   match     out  count == terminal
// -----------------------------------------------------------------------------
module contador_ciclos #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] terminal,
    output logic          match
);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples values from before the clock edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match = (cnt == terminal);

endmodule

// File: rtl/controle_soneca.sv
// -----------------------------------------------------------------------------
// controle_soneca
//   Alarm-session sequencer. An alarme rising edge starts a session that
//   rings the buzzer, allows a limited number of snoozes and ends with a
//   one-cycle desligar pulse on stop or ring timeout.
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous reset, active-low
//   alarme          in   alarm-time-reached level; rising edge starts a session
//   dia_util        in   1 = working day
//   soneca          in   snooze pulse (debounced)
//   parar           in   stop pulse (debounced)
//   campainha       out  buzzer enable (state TOCANDO)
//   desligar        out  one-cycle session-end pulse (state FIM)
//   estado          out  2  current state
//   sonecas_usadas  out  2  snoozes taken in current session
// Configuration
//   ALARME_FDS_EN defined  : sessions also start on non-working days, and
//                            such sessions allow no snoozes.
//   ALARME_FDS_EN undefined: alarm edges with dia_util==0 are ignored.
// -----------------------------------------------------------------------------
module controle_soneca
    import controle_soneca_pkg::*;
#(
    parameter int RING_CYCLES   = RING_CYCLES_DEF,
    parameter int SNOOZE_CYCLES = SNOOZE_CYCLES_DEF,
    parameter int MAX_SONECAS   = MAX_SONECAS_DEF,
    parameter int CW            = CW_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alarme,
    input  logic                dia_util,
    input  logic                soneca,
    input  logic                parar,
    output logic                campainha,
    output logic                desligar,
    output logic [ESTADO_W-1:0] estado,
    output logic [1:0]          sonecas_usadas
);

    localparam logic [1:0]    MAX_S     = 2'(MAX_SONECAS);
    localparam logic [CW-1:0] TERM_RING = CW'(RING_CYCLES - 1);
    localparam logic [CW-1:0] TERM_SNZ  = CW'(SNOOZE_CYCLES - 1);

    estado_t       estado_q;
    estado_t       estado_d;
    logic [1:0]    sonecas_q;
    logic [1:0]    limite;
    logic          alarme_q;
    logic          inicio;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_match;
    logic [CW-1:0] terminal;

    // NOTE: alarme_q deliberately has no reset branch: it keeps following
    // alarme while reset is held, so a level that stays high across a reset
    // is not mistaken for a fresh rising edge afterwards.
    always_ff @(posedge clock) begin
        alarme_q <= alarme;
    end

`ifdef ALARME_FDS_EN
    logic [1:0] limite_q;

    assign inicio = alarme & ~alarme_q;
    assign limite = limite_q;

    // Snooze allowance is fixed when the session starts.
    always_ff @(posedge clock) begin
        if (!reset) begin
            limite_q <= MAX_S;
        end else if (estado_q == OCIOSO && inicio) begin
            limite_q <= dia_util ? MAX_S : 2'd0;
        end
    end
`else
    assign inicio = alarme & ~alarme_q & dia_util;
    assign limite = MAX_S;
`endif

    // Next-state decision, shared by the state register and the counter
    // controls so both always agree on when a transition happens.
    // NOTE: every variable gets a default first, so no latch is inferred.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO: begin
                if (inicio) estado_d = TOCANDO;
            end
            TOCANDO: begin
                if (parar)                               estado_d = FIM;
                else if (soneca && (sonecas_q < limite)) estado_d = SONECA;
                else if (cnt_match)                      estado_d = FIM;
            end
            SONECA: begin
                if (parar)          estado_d = FIM;
                else if (cnt_match) estado_d = TOCANDO;
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // The count restarts on every state change, so it never wraps.
    assign cnt_clr  = (estado_d != estado_q);
    assign cnt_en   = !cnt_clr && (estado_q == TOCANDO || estado_q == SONECA);
    assign terminal = (estado_q == SONECA) ? TERM_SNZ : TERM_RING;

    contador_ciclos #(
        .CW (CW)
    ) u_contador (
        .clock    (clock),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .terminal (terminal),
        .match    (cnt_match)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            sonecas_q <= 2'd0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == OCIOSO && inicio) begin
                sonecas_q <= 2'd0;
            end else if (estado_q == TOCANDO && estado_d == SONECA) begin
                sonecas_q <= sonecas_q + 2'd1;
            end
        end
    end

    assign campainha      = (estado_q == TOCANDO);
    assign desligar       = (estado_q == FIM);
    assign estado         = estado_q;
    assign sonecas_usadas = sonecas_q;

endmodule

// File: tb/tb_controle_soneca.sv
// -----------------------------------------------------------------------------
// tb_controle_soneca
//   Self-checking bench for controle_soneca. A session-level reference model
//   (mode + remaining cycles + snoozes used) is compared against the DUT on
//   every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_controle_soneca;

    localparam int RING   = 16;
    localparam int SNOOZE = 32;
    localparam int MAXS   = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       alarme;
    logic       dia_util;
    logic       soneca;
    logic       parar;
    logic       campainha;
    logic       desligar;
    logic [1:0] estado;
    logic [1:0] sonecas_usadas;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    controle_soneca dut (
        .clock          (clock),
        .reset          (reset),
        .alarme         (alarme),
        .dia_util       (dia_util),
        .soneca         (soneca),
        .parar          (parar),
        .campainha      (campainha),
        .desligar       (desligar),
        .estado         (estado),
        .sonecas_usadas (sonecas_usadas)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (session level) ----------------
    // mode: 0 idle, 1 ringing, 2 snoozing, 3 ending
    int m_mode, m_rem, m_used, m_allowed;
    bit m_prev;
    bit model_ok = 1'b0;

    always @(posedge clock) begin
        bit start;
        bit fds;
`ifdef ALARME_FDS_EN
        fds = 1'b1;
`else
        fds = 1'b0;
`endif
        if (!reset) begin
            m_mode = 0;
            m_used = 0;
            m_rem  = 0;
        end else begin
            start = alarme && !m_prev && (dia_util || fds);
            case (m_mode)
                0: if (start) begin
                    m_mode    = 1;
                    m_rem     = RING;
                    m_used    = 0;
                    m_allowed = (fds && !dia_util) ? 0 : MAXS;
                end
                1: begin
                    if (parar) m_mode = 3;
                    else if (soneca && m_used < m_allowed) begin
                        m_mode = 2;
                        m_rem  = SNOOZE;
                        m_used = m_used + 1;
                    end else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_mode = 3;
                    end
                end
                2: begin
                    if (parar) m_mode = 3;
                    else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_mode = 1;
                            m_rem  = RING;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
        m_prev   = alarme;
        model_ok = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (model_ok) begin
            check("model_estado",    estado,         m_mode);
            check("model_campainha", campainha,      (m_mode == 1));
            check("model_desligar",  desligar,       (m_mode == 3));
            check("model_sonecas",   sonecas_usadas, m_used);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_soneca();
        soneca = 1'b1;
        tick();
        soneca = 1'b0;
    endtask

    initial begin
        reset = 1'b0; alarme = 1'b0; dia_util = 1'b1; soneca = 1'b0; parar = 1'b0;
        repeat (2) tick();
        check("reset_estado", estado, 0);
        check("reset_campainha", campainha, 0);
        check("reset_desligar", desligar, 0);
        check("reset_sonecas", sonecas_usadas, 0);
        reset = 1'b1;
        tick();

        // Timeout: 16 ringing cycles, one desligar cycle, back to idle.
        alarme = 1'b1;
        tick();
        for (int i = 0; i < RING; i++) begin
            check("timeout_campainha", campainha, 1);
            tick();
        end
        check("timeout_desligar", desligar, 1);
        check("timeout_campainha_off", campainha, 0);
        tick();
        check("timeout_idle", estado, 0);
        check("timeout_desligar_once", desligar, 0);

        // Snooze at the 4th ringing cycle, then exhaust snoozes.
        alarme = 1'b0; tick();
        alarme = 1'b1; tick();
        repeat (3) tick();
        pulse_soneca();
        for (int i = 0; i < SNOOZE; i++) begin
            check("snooze_quiet", campainha, 0);
            check("snooze_count", sonecas_usadas, 1);
            tick();
        end
        check("snooze_rings_again", campainha, 1);
        for (int k = 2; k <= MAXS; k++) begin
            pulse_soneca();
            repeat (SNOOZE) tick();
            check("snooze_more_used", sonecas_usadas, k);
            check("snooze_more_ring", campainha, 1);
        end
        pulse_soneca();
        check("snooze_4th_ignored", campainha, 1);
        check("snooze_4th_used", sonecas_usadas, MAXS);
        repeat (14) tick();
        check("snooze_last_ring", campainha, 1);
        tick();
        check("snooze_timeout_end", desligar, 1);
        tick();

        // Stop together with snooze: stop wins, snooze count unchanged.
        alarme = 1'b0; tick();
        alarme = 1'b1; tick();
        pulse_soneca();
        repeat (SNOOZE) tick();
        parar = 1'b1; soneca = 1'b1;
        tick();
        parar = 1'b0; soneca = 1'b0;
        check("stop_desligar", desligar, 1);
        check("stop_sonecas", sonecas_usadas, 1);
        tick();
        check("stop_idle", estado, 0);
        check("stop_single_pulse", desligar, 0);
        check("stop_sonecas_hold", sonecas_usadas, 1);

        // Non-working-day gating.
        alarme = 1'b0; dia_util = 1'b0; tick();
        alarme = 1'b1; tick();
`ifdef ALARME_FDS_EN
        check("fds_rings", campainha, 1);
        pulse_soneca();
        check("fds_no_snooze", estado, 1);
        repeat (20) tick();
`else
        for (int i = 0; i < 4; i++) begin
            check("gate_silent", campainha, 0);
            tick();
        end
`endif
        dia_util = 1'b1; alarme = 1'b0; tick();

        // Reset in the middle of a snooze.
        alarme = 1'b1; tick();
        pulse_soneca();
        check("rst_mid_in_snooze", estado, 2);
        repeat (5) tick();
        reset = 1'b0; tick();
        reset = 1'b1;
        check("rst_mid_estado", estado, 0);
        check("rst_mid_campainha", campainha, 0);
        check("rst_mid_desligar", desligar, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_held_alarme_idle", estado, 0);
            check("rst_no_desligar", desligar, 0);
        end
        alarme = 1'b0; tick();
        alarme = 1'b1; tick();
        check("rst_rearm_rings", campainha, 1);
        parar = 1'b1; tick(); parar = 1'b0;
        tick();
        alarme = 1'b0; tick();

        // Retrigger during ringing: no restart.
        alarme = 1'b1; tick();
        alarme = 1'b0; tick();
        alarme = 1'b1; tick();
        repeat (13) tick();
        check("retrig_still_ring", campainha, 1);
        tick();
        check("retrig_timeout", desligar, 1);
        tick();

        // Randomized stimulus, checked by the model every cycle.
        for (int n = 0; n < 20000; n++) begin
            reset  = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 24) == 0) alarme   = ~alarme;
            if ($urandom_range(0, 39) == 0) dia_util = ~dia_util;
            soneca = ($urandom_range(0, 9) == 0);
            parar  = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
